// File: rtl/vga_sync_if.sv
// Pixel-coordinate and sync bundle driven by vga_sync_gen and consumed by the draw_* blocks
// and the VGA pin/RGB mux logic.
interface vga_sync_if;
  logic [9:0] opixel_x;
  logic [9:0] opixel_y;
  logic       ohsync;
  logic       ovsync;
  logic       ovideo_on;
  logic       opixel_tick;
  logic       oframe_start;

  modport master (
    output opixel_x, opixel_y, ohsync, ovsync, ovideo_on, opixel_tick, oframe_start
  );

  modport slave (
    input opixel_x, opixel_y, ohsync, ovsync, ovideo_on, opixel_tick, oframe_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides the board clock into a pixel tick and produces H/V counters
// with sync and video-on decodes registered alongside them.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_VIS    = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_VIS    = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        iclk,
  input  logic        ireset,
  vga_sync_if.master  vga
);

  localparam int unsigned HTotal = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DivMax  = 4'(CLK_DIV - 1);
  localparam logic [9:0] HMax    = 10'(HTotal - 1);
  localparam logic [9:0] VMax    = 10'(VTotal - 1);
  localparam logic [9:0] HVis    = 10'(H_VIS);
  localparam logic [9:0] VVis    = 10'(V_VIS);
  localparam logic [9:0] HsFirst = 10'(H_VIS + H_FP);
  localparam logic [9:0] HsLast  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VsFirst = 10'(V_VIS + V_FP);
  localparam logic [9:0] VsLast  = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [3:0] div_cnt_d, div_cnt_q;
  logic [9:0] x_d, x_q;
  logic [9:0] y_d, y_q;
  logic       hsync_d, hsync_q;
  logic       vsync_d, vsync_q;
  logic       video_on_d, video_on_q;
  logic       tick_d, tick_q;
  logic       frame_start_d, frame_start_q;
  logic       tick_int;

  always_comb begin
    tick_int  = (div_cnt_q == DivMax);
    div_cnt_d = tick_int ? 4'd0 : div_cnt_q + 4'd1;
    x_d       = x_q;
    y_d       = y_q;
    if (tick_int) begin
      if (x_q == HMax) begin
        x_d = 10'd0;
        y_d = (y_q == VMax) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    // Decode from the next coordinate so every output lines up with opixel_x/opixel_y.
    hsync_d       = ((x_d >= HsFirst) && (x_d <= HsLast)) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = ((y_d >= VsFirst) && (y_d <= VsLast)) ? SYNC_POL : ~SYNC_POL;
    video_on_d    = (x_d < HVis) && (y_d < VVis);
    tick_d        = tick_int;
    frame_start_d = tick_int && (x_q == HMax) && (y_q == VMax);
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      div_cnt_q     <= 4'd0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b1;
      tick_q        <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      tick_q        <= tick_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.opixel_x     = x_q;
  assign vga.opixel_y     = y_q;
  assign vga.ohsync       = hsync_q;
  assign vga.ovsync       = vsync_q;
  assign vga.ovideo_on    = video_on_q;
  assign vga.opixel_tick  = tick_q;
  assign vga.oframe_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: a default 640x480 build checks reset and line timing, a reduced-geometry
// CLK_DIV=1 build checks frame wrap, vsync, frame_start and mid-frame reset.
module tb_vga_sync_gen;

  typedef struct {
    int unsigned idx;
    int          x;
    int          y;
    bit          hs;
    bit          vs;
    bit          vid;
    bit          fs;
  } exp_t;

  logic iclk = 1'b0;
  logic rst_d = 1'b1;
  logic rst_s = 1'b1;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  exp_t q_d[$];
  exp_t q_s[$];
  exp_t e_d, e_s;
  int unsigned cnt_d = 0, hlow_d = 0;
  int unsigned cnt_s = 0, nolow_s = 0, fs_cnt_s = 0;

  vga_sync_if vif_d ();
  vga_sync_if vif_s ();

  vga_sync_gen u_dut (
    .iclk   (iclk),
    .ireset (rst_d),
    .vga    (vif_d)
  );

  // Small geometry: H_TOTAL=15, hsync x=10..12; V_TOTAL=11, vsync y=8..9; frame = 165 ticks.
  vga_sync_gen #(
    .CLK_DIV (1),
    .H_VIS   (8),
    .H_FP    (2),
    .H_SYNC  (3),
    .H_BP    (2),
    .V_VIS   (6),
    .V_FP    (2),
    .V_SYNC  (2),
    .V_BP    (1)
  ) u_dut_s (
    .iclk   (iclk),
    .ireset (rst_s),
    .vga    (vif_s)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string name, input int act, input int req);
    total_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic cmp(input string tag, input exp_t e, input int x, input int y,
                     input bit hs, input bit vs, input bit vid, input bit fs);
    chk($sformatf("%s_x@%0d", tag, e.idx), x, e.x);
    chk($sformatf("%s_y@%0d", tag, e.idx), y, e.y);
    chk($sformatf("%s_hsync@%0d", tag, e.idx), int'(hs), int'(e.hs));
    chk($sformatf("%s_vsync@%0d", tag, e.idx), int'(vs), int'(e.vs));
    chk($sformatf("%s_video_on@%0d", tag, e.idx), int'(vid), int'(e.vid));
    chk($sformatf("%s_frame_start@%0d", tag, e.idx), int'(fs), int'(e.fs));
  endtask

  task automatic push_d(input int unsigned n, input int x, input int y,
                        input bit hs, input bit vs, input bit vid, input bit fs);
    exp_t e;
    e = '{idx: n, x: x, y: y, hs: hs, vs: vs, vid: vid, fs: fs};
    q_d.push_back(e);
  endtask

  task automatic push_s(input int unsigned n, input int x, input int y,
                        input bit hs, input bit vs, input bit vid, input bit fs);
    exp_t e;
    e = '{idx: n, x: x, y: y, hs: hs, vs: vs, vid: vid, fs: fs};
    q_s.push_back(e);
  endtask

  task automatic check_reset(input string tag, input int x, input int y, input bit hs,
                             input bit vs, input bit vid, input bit tk, input bit fs);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_hsync"}, int'(hs), 1);
    chk({tag, "_vsync"}, int'(vs), 1);
    chk({tag, "_video_on"}, int'(vid), 1);
    chk({tag, "_tick"}, int'(tk), 0);
    chk({tag, "_frame_start"}, int'(fs), 0);
  endtask

  task automatic wait_d(input int unsigned target);
    for (int i = 0; i < 20000 && cnt_d < target; i++) @(negedge iclk);
    chk($sformatf("reach_d_%0d", target), int'(cnt_d >= target), 1);
  endtask

  task automatic wait_s(input int unsigned target);
    for (int i = 0; i < 20000 && cnt_s < target; i++) @(negedge iclk);
    chk($sformatf("reach_s_%0d", target), int'(cnt_s >= target), 1);
  endtask

  // Monitor for the default build: counts ticks since reset release and scores checkpoints.
  always @(posedge iclk) begin
    #1;
    if (rst_d) begin
      cnt_d  = 0;
      hlow_d = 0;
    end else if (vif_d.opixel_tick) begin
      cnt_d++;
      if (cnt_d <= 800 && !vif_d.ohsync) hlow_d++;
      while (q_d.size() > 0 && q_d[0].idx < cnt_d) begin
        e_d = q_d.pop_front();
        chk("d_checkpoint_missed", int'(cnt_d), int'(e_d.idx));
      end
      if (q_d.size() > 0 && q_d[0].idx == cnt_d) begin
        e_d = q_d.pop_front();
        cmp("d", e_d, int'(vif_d.opixel_x), int'(vif_d.opixel_y), vif_d.ohsync,
            vif_d.ovsync, vif_d.ovideo_on, vif_d.oframe_start);
      end
    end
  end

  always @(posedge iclk) begin
    #1;
    if (rst_s) begin
      cnt_s    = 0;
      nolow_s  = 0;
      fs_cnt_s = 0;
    end else begin
      if (!vif_s.opixel_tick) nolow_s++;
      if (vif_s.oframe_start) fs_cnt_s++;
      if (vif_s.opixel_tick) begin
        cnt_s++;
        while (q_s.size() > 0 && q_s[0].idx < cnt_s) begin
          e_s = q_s.pop_front();
          chk("s_checkpoint_missed", int'(cnt_s), int'(e_s.idx));
        end
        if (q_s.size() > 0 && q_s[0].idx == cnt_s) begin
          e_s = q_s.pop_front();
          cmp("s", e_s, int'(vif_s.opixel_x), int'(vif_s.opixel_y), vif_s.ohsync,
              vif_s.ovsync, vif_s.ovideo_on, vif_s.oframe_start);
        end
      end
    end
  end

  initial begin
    // Default build: reset state and first-tick latency.
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    check_reset("d_reset", int'(vif_d.opixel_x), int'(vif_d.opixel_y), vif_d.ohsync,
                vif_d.ovsync, vif_d.ovideo_on, vif_d.opixel_tick, vif_d.oframe_start);

    //     tick  x    y  hs vs vid fs
    push_d(1,    1,   0, 1, 1, 1,  0);
    push_d(639,  639, 0, 1, 1, 1,  0);
    push_d(640,  640, 0, 1, 1, 0,  0);
    push_d(655,  655, 0, 1, 1, 0,  0);
    push_d(656,  656, 0, 0, 1, 0,  0);
    push_d(751,  751, 0, 0, 1, 0,  0);
    push_d(752,  752, 0, 1, 1, 0,  0);
    push_d(799,  799, 0, 1, 1, 0,  0);
    push_d(800,  0,   1, 1, 1, 1,  0);
    push_d(1000, 200, 1, 1, 1, 1,  0);
    rst_d = 1'b0;

    @(negedge iclk);
    chk("d_tick_after_1_clk", int'(vif_d.opixel_tick), 0);
    @(negedge iclk);
    chk("d_tick_after_2_clk", int'(vif_d.opixel_tick), 1);
    chk("d_x_after_first_tick", int'(vif_d.opixel_x), 1);

    wait_d(800);
    chk("d_hsync_low_ticks", int'(hlow_d), 96);

    // Mid-line reset at (300,1) must restart at the origin without a frame_start pulse.
    wait_d(1100);
    chk("d_pre_reset_x", int'(vif_d.opixel_x), 300);
    chk("d_pre_reset_y", int'(vif_d.opixel_y), 1);
    rst_d = 1'b1;
    @(negedge iclk);
    check_reset("d_midreset", int'(vif_d.opixel_x), int'(vif_d.opixel_y), vif_d.ohsync,
                vif_d.ovsync, vif_d.ovideo_on, vif_d.opixel_tick, vif_d.oframe_start);
    chk("d_queue_drained", q_d.size(), 0);

    // Reduced build, CLK_DIV=1.
    @(negedge iclk);
    check_reset("s_reset", int'(vif_s.opixel_x), int'(vif_s.opixel_y), vif_s.ohsync,
                vif_s.ovsync, vif_s.ovideo_on, vif_s.opixel_tick, vif_s.oframe_start);

    //     tick x   y   hs vs vid fs
    push_s(1,   1,  0,  1, 1, 1,  0);
    push_s(8,   8,  0,  1, 1, 0,  0);
    push_s(9,   9,  0,  1, 1, 0,  0);
    push_s(10,  10, 0,  0, 1, 0,  0);
    push_s(12,  12, 0,  0, 1, 0,  0);
    push_s(13,  13, 0,  1, 1, 0,  0);
    push_s(82,  7,  5,  1, 1, 1,  0);
    push_s(90,  0,  6,  1, 1, 0,  0);
    push_s(119, 14, 7,  1, 1, 0,  0);
    push_s(120, 0,  8,  1, 0, 0,  0);
    push_s(149, 14, 9,  1, 0, 0,  0);
    push_s(150, 0,  10, 1, 1, 0,  0);
    push_s(164, 14, 10, 1, 1, 0,  0);
    push_s(165, 0,  0,  1, 1, 1,  1);
    push_s(166, 1,  0,  1, 1, 1,  0);
    push_s(330, 0,  0,  1, 1, 1,  1);
    rst_s = 1'b0;

    wait_s(330);
    chk("s_frame_start_pulses", int'(fs_cnt_s), 2);
    chk("s_tick_low_cycles", int'(nolow_s), 0);

    // 380 ticks = 2 frames + 50 -> (5,3); reset there.
    wait_s(380);
    chk("s_pre_reset_x", int'(vif_s.opixel_x), 5);
    chk("s_pre_reset_y", int'(vif_s.opixel_y), 3);
    rst_s = 1'b1;
    @(negedge iclk);
    check_reset("s_midreset", int'(vif_s.opixel_x), int'(vif_s.opixel_y), vif_s.ohsync,
                vif_s.ovsync, vif_s.ovideo_on, vif_s.opixel_tick, vif_s.oframe_start);
    chk("s_queue_drained", q_s.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
